// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator for the HDMI output path.
// Produces hsync/vsync/de plus active-area pixel coordinates and
// line/frame start pulses. Everything advances only on pix_en cycles, and
// the outputs are registered so they show the counter position from the
// previous enable cycle.
//
// Build option: define VTG_HALF_RES_EN to report coordinates halved
// (0..319 x 0..239 at default timing) so a quarter-size source can be
// pixel- and line-doubled. Without it, full-resolution coordinates are
// reported.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] h_count,
    output logic [8:0] v_count,
    output logic       line_start,
    output logic       frame_start
);

    // Timing boundaries expressed at counter width.
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       SYNC_ON  = (SYNC_POL != 0);
    localparam logic       SYNC_OFF = (SYNC_POL == 0);

    // Blanking coordinates: all-ones so any downstream range test fails.
    localparam logic [9:0] H_BLANK  = 10'h3FF;
    localparam logic [8:0] V_BLANK  = 9'h1FF;

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       de_q, de_d;
    logic [9:0] h_count_q, h_count_d;
    logic [8:0] v_count_q, v_count_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    logic       h_act;
    logic       v_act;

    // Region decode of the current counter position.
    always_comb begin
        h_act = (hc_q < H_ACT);
        v_act = (vc_q < V_ACT);
    end

    // Raster counters: hc wraps each line, vc wraps each frame.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (pix_en) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    // Output next-state: levels hold without pix_en, pulses drop to 0.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        h_count_d     = h_count_q;
        v_count_d     = v_count_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_en) begin
            hsync_d = ((hc_q >= HS_BEG) && (hc_q < HS_END)) ? SYNC_ON : SYNC_OFF;
            vsync_d = ((vc_q >= VS_BEG) && (vc_q < VS_END)) ? SYNC_ON : SYNC_OFF;
            de_d    = h_act && v_act;
            if (h_act && v_act) begin
`ifdef VTG_HALF_RES_EN
                h_count_d = {1'b0, hc_q[9:1]};
                v_count_d = vc_q[9:1];
`else
                h_count_d = hc_q;
                v_count_d = vc_q[8:0];
`endif
            end else begin
                h_count_d = H_BLANK;
                v_count_d = V_BLANK;
            end
            line_start_d  = (hc_q == 10'd0) && v_act;
            frame_start_d = (hc_q == 10'd0) && (vc_q == 10'd0);
        end
    end

    // State and output registers; reset aborts the frame immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc_q          <= '0;
            vc_q          <= '0;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            de_q          <= 1'b0;
            h_count_q     <= H_BLANK;
            v_count_q     <= V_BLANK;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign h_count     = h_count_q;
    assign v_count     = v_count_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
